// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, colour constants and the test-bar palette.
package vga_pkg;

    typedef logic [11:0] rgb12;

    localparam int unsigned DEF_CLK_DIV      = 4;
    localparam int unsigned DEF_H_TOTAL      = 800;
    localparam int unsigned DEF_H_SYNC       = 96;
    localparam int unsigned DEF_H_DISP_START = 144;
    localparam int unsigned DEF_H_DISP_END   = 784;
    localparam int unsigned DEF_V_TOTAL      = 525;
    localparam int unsigned DEF_V_SYNC       = 2;
    localparam int unsigned DEF_V_DISP_START = 35;
    localparam int unsigned DEF_V_DISP_END   = 515;

    localparam rgb12 RED     = 12'hF00;
    localparam rgb12 GREEN   = 12'h0F0;
    localparam rgb12 BLUE    = 12'h00F;
    localparam rgb12 BLACK   = 12'h000;
    localparam rgb12 WHITE   = 12'hFFF;
    localparam rgb12 YELLOW  = 12'hFF0;
    localparam rgb12 CYAN    = 12'h0FF;
    localparam rgb12 MAGENTA = 12'hF0F;

    localparam int unsigned BAR_W = 80;

    function automatic rgb12 bar_colour(input logic [2:0] idx);
        rgb12 c;
        unique case (idx)
            3'd0:    c = WHITE;
            3'd1:    c = YELLOW;
            3'd2:    c = CYAN;
            3'd3:    c = GREEN;
            3'd4:    c = MAGENTA;
            3'd5:    c = RED;
            3'd6:    c = BLUE;
            default: c = BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with enable, terminal-count flag and sync/active decodes.
module vga_axis_counter #(
    parameter int unsigned TOTAL      = 800,
    parameter int unsigned SYNC       = 96,
    parameter int unsigned DISP_START = 144,
    parameter int unsigned DISP_END   = 784,
    parameter int unsigned WIDTH      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             in_sync,
    output logic             active
);

    localparam logic [WIDTH-1:0] LAST    = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH-1:0] SYNC_W  = WIDTH'(SYNC);
    localparam logic [WIDTH-1:0] START_W = WIDTH'(DISP_START);
    localparam logic [WIDTH-1:0] END_W   = WIDTH'(DISP_END);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= wrap ? '0 : count_q + WIDTH'(1);
        end
    end

    assign count   = count_q;
    assign wrap    = (count_q == LAST);
    assign in_sync = (count_q < SYNC_W);
    assign active  = (count_q >= START_W) && (count_q < END_W);

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing with a one-pixel registered sync/colour output stage.
// Optional VGA_TEST_PATTERN_EN adds test_sel, selecting eight vertical colour bars.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV      = DEF_CLK_DIV,
    parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
    parameter int unsigned H_SYNC       = DEF_H_SYNC,
    parameter int unsigned H_DISP_START = DEF_H_DISP_START,
    parameter int unsigned H_DISP_END   = DEF_H_DISP_END,
    parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
    parameter int unsigned V_SYNC       = DEF_V_SYNC,
    parameter int unsigned V_DISP_START = DEF_V_DISP_START,
    parameter int unsigned V_DISP_END   = DEF_V_DISP_END
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] rgb_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_sel,
`endif
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        bright,
    output logic        pix_en,
    output logic        frame_start,
    output logic        hSync,
    output logic        vSync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic             h_wrap, h_sync, h_active;
    logic             v_wrap, v_sync, v_active;
    logic             frame_start_q;
    logic             hsync_q, vsync_q;
    rgb12             colour_q, pix_colour, colour_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else if (pix_en) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    assign pix_en = (div_q == DIV_LAST);

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .SYNC       (H_SYNC),
        .DISP_START (H_DISP_START),
        .DISP_END   (H_DISP_END),
        .WIDTH      (10)
    ) u_h_axis (
        .clk     (clk),
        .rst     (rst),
        .inc     (pix_en),
        .count   (hCount),
        .wrap    (h_wrap),
        .in_sync (h_sync),
        .active  (h_active)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .SYNC       (V_SYNC),
        .DISP_START (V_DISP_START),
        .DISP_END   (V_DISP_END),
        .WIDTH      (10)
    ) u_v_axis (
        .clk     (clk),
        .rst     (rst),
        .inc     (pix_en & h_wrap),
        .count   (vCount),
        .wrap    (v_wrap),
        .in_sync (v_sync),
        .active  (v_active)
    );

    assign bright = h_active & v_active;

    always_comb begin
        pix_colour = rgb_in;
`ifdef VGA_TEST_PATTERN_EN
        if (test_sel) begin
            // Only meaningful inside the active area; masked by bright below.
            pix_colour = bar_colour(3'((hCount - 10'(H_DISP_START)) / 10'(BAR_W)));
        end
`endif
        colour_d = bright ? pix_colour : BLACK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start_q <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            colour_q      <= BLACK;
        end else begin
            // Set on the edge that steps the counters to (0,0).
            frame_start_q <= pix_en & h_wrap & v_wrap;
            if (pix_en) begin
                hsync_q  <= ~h_sync;
                vsync_q  <= ~v_sync;
                colour_q <= colour_d;
            end
        end
    end

    assign frame_start = frame_start_q;
    assign hSync       = hsync_q;
    assign vSync       = vsync_q;
    assign vga_r       = colour_q[11:8];
    assign vga_g       = colour_q[7:4];
    assign vga_b       = colour_q[3:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench: default-timing instance plus a scaled-down instance, both checked
// every clock against an arithmetic raster model driven by the clock count since reset.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] rgb_in = 12'h000;
    logic        test_sel = 1'b0;

    // index 0: default 640x480 timing, index 1: small raster
    int unsigned CD[2]  = '{4, 4};
    int unsigned HT[2]  = '{800, 40};
    int unsigned HS[2]  = '{96, 6};
    int unsigned HDS[2] = '{144, 10};
    int unsigned HDE[2] = '{784, 34};
    int unsigned VT[2]  = '{525, 20};
    int unsigned VS[2]  = '{2, 2};
    int unsigned VDS[2] = '{35, 4};
    int unsigned VDE[2] = '{515, 18};
    logic [11:0] BARS[8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                             12'hF0F, 12'hF00, 12'h00F, 12'h000};

    logic [9:0] d_h, d_v, s_h, s_v;
    logic       d_br, d_pe, d_fs, d_hs, d_vs, s_br, s_pe, s_fs, s_hs, s_vs;
    logic [3:0] d_r, d_g, d_b, s_r, s_g, s_b;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned k = 0;
    logic [11:0] exp_col[2];
    bit          const_phase = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen dut_d (
        .clk (clk), .rst (rst), .rgb_in (rgb_in),
`ifdef VGA_TEST_PATTERN_EN
        .test_sel (test_sel),
`endif
        .hCount (d_h), .vCount (d_v), .bright (d_br), .pix_en (d_pe),
        .frame_start (d_fs), .hSync (d_hs), .vSync (d_vs),
        .vga_r (d_r), .vga_g (d_g), .vga_b (d_b)
    );

    vga_timing_gen #(
        .CLK_DIV (4), .H_TOTAL (40), .H_SYNC (6), .H_DISP_START (10), .H_DISP_END (34),
        .V_TOTAL (20), .V_SYNC (2), .V_DISP_START (4), .V_DISP_END (18)
    ) dut_s (
        .clk (clk), .rst (rst), .rgb_in (rgb_in),
`ifdef VGA_TEST_PATTERN_EN
        .test_sel (test_sel),
`endif
        .hCount (s_h), .vCount (s_v), .bright (s_br), .pix_en (s_pe),
        .frame_start (s_fs), .hSync (s_hs), .vSync (s_vs),
        .vga_r (s_r), .vga_g (s_g), .vga_b (s_b)
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s actual=%0h expected=%0h k=%0d", name, act, exp, k);
        end
    endtask

    // Raster state after kk clock edges since reset release.
    task automatic model(input int c, input int unsigned kk, output int unsigned h,
                         output int unsigned v, output bit br, output bit pe, output bit fs,
                         output bit hs, output bit vs);
        int unsigned div, pix, p;
        div = kk % CD[c];
        pix = kk / CD[c];
        h   = pix % HT[c];
        v   = (pix / HT[c]) % VT[c];
        br  = (h >= HDS[c]) && (h < HDE[c]) && (v >= VDS[c]) && (v < VDE[c]);
        pe  = (div == CD[c] - 1);
        fs  = (div == 0) && (pix != 0) && (pix % (HT[c] * VT[c]) == 0);
        if (pix == 0) begin
            hs = 1'b1;
            vs = 1'b1;
        end else begin
            p  = pix - 1;
            hs = !((p % HT[c]) < HS[c]);
            vs = !(((p / HT[c]) % VT[c]) < VS[c]);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    // Colour seen on the pins: what the source offered at the last pixel edge, masked.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_col[0] <= 12'h000;
            exp_col[1] <= 12'h000;
        end else begin
            for (int c = 0; c < 2; c++) begin
                int unsigned h, v;
                bit br, pe, fs, hs, vs;
                logic [11:0] src;
                model(c, k, h, v, br, pe, fs, hs, vs);
                src = rgb_in;
`ifdef VGA_TEST_PATTERN_EN
                if (test_sel && br) src = BARS[(h - HDS[c]) / 80];
`endif
                if (pe) exp_col[c] <= br ? src : 12'h000;
            end
        end
    end

    task automatic check_inst(input int c, input string n, input logic [9:0] h_a,
                              input logic [9:0] v_a, input logic br_a, input logic pe_a,
                              input logic fs_a, input logic hs_a, input logic vs_a,
                              input logic [11:0] col_a);
        int unsigned h, v;
        bit br, pe, fs, hs, vs;
        model(c, k, h, v, br, pe, fs, hs, vs);
        check({n, ".hCount"}, h_a, h);
        check({n, ".vCount"}, v_a, v);
        check({n, ".bright"}, br_a, br);
        check({n, ".pix_en"}, pe_a, pe);
        check({n, ".frame_start"}, fs_a, fs);
        check({n, ".hSync"}, hs_a, hs);
        check({n, ".vSync"}, vs_a, vs);
        check({n, ".rgb"}, col_a, exp_col[c]);
    endtask

    int unsigned hs_run = 0, vs_run = 0, lit_cnt = 0, last_fs_k = 0;
    bit          lit_valid = 1'b0;

    always @(negedge clk) begin
        check_inst(0, "d", d_h, d_v, d_br, d_pe, d_fs, d_hs, d_vs, {d_r, d_g, d_b});
        check_inst(1, "s", s_h, s_v, s_br, s_pe, s_fs, s_hs, s_vs, {s_r, s_g, s_b});
        if (rst) begin
            hs_run = 0; vs_run = 0; lit_cnt = 0; last_fs_k = 0; lit_valid = 1'b0;
        end else begin
            if (!d_hs) hs_run++;
            else if (hs_run != 0) begin
                check("d.hsync_low_clks", hs_run, 384);
                hs_run = 0;
            end
            if (!s_vs) vs_run++;
            else if (vs_run != 0) begin
                check("s.vsync_low_clks", vs_run, 320);
                vs_run = 0;
            end
            if (s_fs) begin
                check("s.frame_period", k - last_fs_k, 3200);
                last_fs_k = k;
                if (lit_valid) check("s.lit_pixels", lit_cnt, 336);
                lit_cnt   = 0;
                lit_valid = const_phase;
            end
            if ((k % 4) == 0 && s_r == 4'hF) lit_cnt++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            rgb_in   = const_phase ? 12'hF00 : 12'($urandom);
            test_sel = 1'($urandom);
        end
    end

    task automatic at_k(input int unsigned n);
        int unsigned guard = 0;
        @(negedge clk);
        while (k != n && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        if (k != n) begin
            $display("FAIL at_k timeout actual=%0d expected=%0d", k, n);
            failures++;
        end
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        at_k(2);    check("lit.d.pix_en@2", d_pe, 0);
        at_k(3);    check("lit.d.pix_en@3", d_pe, 1);
                    check("lit.d.hSync@3", d_hs, 1);
        at_k(4);    check("lit.d.hCount@4", d_h, 1);
                    check("lit.d.hSync@4", d_hs, 0);
        at_k(7);    check("lit.d.pix_en@7", d_pe, 1);
        at_k(387);  check("lit.d.hSync@387", d_hs, 0);
        at_k(388);  check("lit.d.hSync@388", d_hs, 1);
        at_k(3199); check("lit.d.hCount@3199", d_h, 799);
                    check("lit.s.vCount@3199", s_v, 19);
        at_k(3200); check("lit.d.hCount@3200", d_h, 0);
                    check("lit.d.vCount@3200", d_v, 1);
                    check("lit.s.frame_start@3200", s_fs, 1);
        at_k(7000); const_phase = 1'b1;
        // small raster now at h=20,v=10 (visible), showing pixel h=19 in red
        at_k(8081); check("lit.s.vga_r_pre_rst", s_r, 4'hF);
                    check("lit.s.hCount_pre_rst", s_h, 20);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("lit.rst.s.hCount", s_h, 0);
        check("lit.rst.s.vCount", s_v, 0);
        check("lit.rst.s.vga_r", s_r, 0);
        check("lit.rst.s.hSync", s_hs, 1);
        check("lit.rst.s.vSync", s_vs, 1);
        check("lit.rst.d.hCount", d_h, 0);
        check("lit.rst.d.vCount", d_v, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        at_k(3);    check("lit.rel.s.pix_en@3", s_pe, 1);
        at_k(3200); check("lit.rel.s.frame_start", s_fs, 1);
                    check("lit.rel.s.hCount", s_h, 0);
        at_k(6410);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
